muldiv_unit: RTL

//  Multi-cycle RV32M execution unit. Consumes the 5-bit ALU op codes emitted by the ALU decoder
//  (mul/mulh/mulhsu/mulhu/div/divu/rem/remu, codes 01010..10001) plus two operands.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/serial_divider.sv | 65 ++++++
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, datapath width and the
// mul/div unit state encoding.
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [4:0] ALU_MUL    = 5'b01010;
   localparam logic [4:0] ALU_MULH   = 5'b01011;
   localparam logic [4:0] ALU_MULHSU = 5'b01100;
   localparam logic [4:0] ALU_MULHU  = 5'b01101;
   localparam logic [4:0] ALU_DIV    = 5'b01110;
   localparam logic [4:0] ALU_DIVU   = 5'b01111;
   localparam logic [4:0] ALU_REM    = 5'b10000;
   localparam logic [4:0] ALU_REMU   = 5'b10001;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } md_state_t;

   function automatic logic is_mul_op(input logic [4:0] op);
      return (op == ALU_MUL) || (op == ALU_MULH) ||
             (op == ALU_MULHSU) || (op == ALU_MULHU);
   endfunction

   function automatic logic is_div_op(input logic [4:0] op);
      return (op == ALU_DIV) || (op == ALU_DIVU) ||
             (op == ALU_REM) || (op == ALU_REMU);
   endfunction

endpackage

// File: rtl/serial_divider.sv
// Radix-2 restoring divider on unsigned magnitudes, one
// quotient bit per cycle, MSB first.
module serial_divider
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic            run_q;
   logic [4:0]      cnt_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN:0]   rem_q;
   logic [XLEN-1:0] dvs_q;

   logic [XLEN:0]   rem_sh;
   logic [XLEN:0]   rem_nx;
   logic [XLEN-1:0] quo_nx;
   logic            ge;
   logic            unused_msb;

   // quo_q starts as the dividend and shifts quotient bits in from the LSB
   assign rem_sh = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
   assign ge     = rem_sh >= {1'b0, dvs_q};
   assign rem_nx = ge ? rem_sh - {1'b0, dvs_q} : rem_sh;
   assign quo_nx = {quo_q[XLEN-2:0], ge};

   assign done       = run_q && (cnt_q == 5'd0);
   assign quotient   = quo_nx;
   assign remainder  = rem_nx[XLEN-1:0];
   assign unused_msb = rem_q[XLEN] ^ rem_nx[XLEN];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q <= 1'b0;
         cnt_q <= 5'd0;
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else if (kill) begin
         run_q <= 1'b0;
         cnt_q <= 5'd0;
      end else if (start) begin
         run_q <= 1'b1;
         cnt_q <= 5'(XLEN - 1);
         quo_q <= dividend;
         rem_q <= '0;
         dvs_q <= divisor;
      end else if (run_q) begin
         quo_q <= quo_nx;
         rem_q <= rem_nx;
         cnt_q <= cnt_q - 5'd1;
         if (cnt_q == 5'd0)
            run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execution unit: single-cycle multiply, serial divide,
// valid/ready handshake toward the EX stage.
module muldiv_unit
   import alu_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [4:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            kill_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   md_state_t       state_q, state_d;
   logic [4:0]      op_q;
   logic [XLEN-1:0] a_q, b_q;
   logic [XLEN-1:0] res_q, res_d;

   logic            accept;
   logic            mul_i, div_i, sgn_i, rem_i;
   logic            b_zero, ovf;
   logic [XLEN-1:0] spec_res;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            dv_start, dv_done;
   logic [XLEN-1:0] dv_quo, dv_rem;

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign result_o    = res_q;

   assign accept = in_valid_i && in_ready_o && !kill_i;
   assign mul_i  = is_mul_op(op_i);
   assign div_i  = is_div_op(op_i);
   assign sgn_i  = (op_i == ALU_DIV) || (op_i == ALU_REM);
   assign rem_i  = (op_i == ALU_REM) || (op_i == ALU_REMU);

   assign b_zero = (b_i == '0);
   assign ovf    = sgn_i && (a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (b_i == '1);

   // Special cases resolve straight from the request operands
   always_comb begin
      spec_res = '0;
      if (b_zero)
         spec_res = rem_i ? a_i : '1;
      else if (ovf)
         spec_res = rem_i ? '0 : a_i;
   end

   assign a_mag    = (sgn_i && a_i[XLEN-1]) ? -a_i : a_i;
   assign b_mag    = (sgn_i && b_i[XLEN-1]) ? -b_i : b_i;
   assign dv_start = accept && div_i && !b_zero && !ovf;

   serial_divider u_div (
      .clk       (clk_i),
      .rst       (rst_i),
      .start     (dv_start),
      .kill      (kill_i),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .done      (dv_done),
      .quotient  (dv_quo),
      .remainder (dv_rem)
   );

   logic                   sa, sb;
   logic signed [XLEN:0]   a_x, b_x;
   logic [2*XLEN-1:0]      prod;
   logic [XLEN-1:0]        mul_res;

   assign sa      = (op_q == ALU_MULH) || (op_q == ALU_MULHSU);
   assign sb      = (op_q == ALU_MULH);
   assign a_x     = {sa & a_q[XLEN-1], a_q};
   assign b_x     = {sb & b_q[XLEN-1], b_q};
   assign prod    = (2*XLEN)'(a_x * b_x);
   assign mul_res = (op_q == ALU_MUL) ? prod[XLEN-1:0]
                                      : prod[2*XLEN-1:XLEN];

   logic            sgn_q, rem_op_q;
   logic [XLEN-1:0] q_fix, r_fix, div_res;

   assign sgn_q    = (op_q == ALU_DIV) || (op_q == ALU_REM);
   assign rem_op_q = (op_q == ALU_REM) || (op_q == ALU_REMU);
   assign q_fix    = (sgn_q && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -dv_quo
                                                            : dv_quo;
   assign r_fix    = (sgn_q && a_q[XLEN-1]) ? -dv_rem : dv_rem;
   assign div_res  = rem_op_q ? r_fix : q_fix;

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      if (kill_i) begin
         state_d = IDLE;
         res_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  unique case (1'b1)
                     mul_i: state_d = MUL;
                     div_i: begin
                        if (b_zero || ovf) begin
                           state_d = DONE;
                           res_d   = spec_res;
                        end else begin
                           state_d = DIV;
                        end
                     end
                     default: begin
                        state_d = DONE;
                        res_d   = '0;
                     end
                  endcase
               end
            end
            MUL: begin
               state_d = DONE;
               res_d   = mul_res;
            end
            DIV: begin
               if (dv_done) begin
                  state_d = DONE;
                  res_d   = div_res;
               end
            end
            DONE: begin
               if (out_ready_i)
                  state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         res_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         if (accept) begin
            op_q <= op_i;
            a_q  <= a_i;
            b_q  <= b_i;
         end
      end
   end

endmodule
